// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle MIPS-style datapath
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    JEX     = 4'd10,
    ADDIWB  = 4'd11
  } state_t;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t cur, nxt;
  logic pc_write, branch, irw, mw, rw;
  // state register; reset lands in FETCH from any state
  always_ff @(posedge clk)
    cur <= reset ? FETCH : nxt;
  // next-state and per-state control decode
  always_comb begin
    nxt        = FETCH;
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    iord       = 1'b0;
    irw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (cur)
      FETCH: begin
        nxt       = DECODE;
        alu_src_b = 2'b01;
        irw       = 1'b1;
        pc_write  = 1'b1;
      end
      DECODE: begin
        nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
              (op == OP_R)                 ? RTYPEEX :
              (op == OP_BEQ)               ? BEQEX :
              (op == OP_ADDI)              ? ADDIEX :
              (op == OP_J)                 ? JEX : FETCH;
        alu_src_b = 2'b11;
      end
      MEMADR: begin
        nxt       = (op == OP_LW) ? MEMRD : MEMWR;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        nxt  = MEMWB;
        iord = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        rw         = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        mw   = 1'b1;
      end
      RTYPEEX: begin
        nxt       = RTYPEWB;
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      RTYPEWB: begin
        reg_dst = 1'b1;
        rw      = 1'b1;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      ADDIEX: begin
        nxt       = ADDIWB;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      ADDIWB: rw = 1'b1;
      default: nxt = FETCH;
    endcase
  end
  assign ir_write  = irw & ~reset;
  assign mem_write = mw & ~reset;
  assign reg_write = rw & ~reset;
  assign pc_en     = (pc_write | (branch & zero)) & ~reset;
  assign state     = cur;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction stream checked against a path/table model
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'd0;
  logic [1:0] alu_op, alu_src_b, pc_src;
  logic alu_src_a, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_en;
  logic [3:0] state;
  int errors = 0, checks = 0;
  int path[$];
  int idx;
  logic [5:0] cur_op;
  logic [14:0] tab [16];
  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .pc_en(pc_en), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic set_path(input logic [5:0] o);
    cur_op = o;
    idx = 0;
    case (o)
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000000: path = '{0, 1, 6, 7};
      6'b001000: path = '{0, 1, 9, 11};
      6'b000100: path = '{0, 1, 8};
      6'b000010: path = '{0, 1, 10};
      default:   path = '{0, 1};
    endcase
  endtask
  task automatic step(input logic rst_in, input logic z);
    logic [14:0] e;
    logic [12:0] got;
    @(negedge clk);
    reset = rst_in;
    zero  = z;
    op    = (path[idx] == 1 || path[idx] == 2) ? cur_op : 6'($urandom);
    #1;
    e   = tab[path[idx]];
    got = {alu_op, alu_src_a, alu_src_b, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_src};
    check($sformatf("state(op=%b)", cur_op), 32'(state), 32'(path[idx]));
    check($sformatf("ctl(s=%0d,r=%0b)", path[idx], rst_in), 32'(got), 32'(rst_in ? (e[12:0] & ~13'h070) : e[12:0]));
    check($sformatf("pc_en(s=%0d,z=%0b,r=%0b)", path[idx], z, rst_in), 32'(pc_en), 32'(!rst_in && (e[14] || (e[13] && z))));
    @(posedge clk);
    if (!rst_in) idx++;
  endtask
  task automatic run_instr(input logic [5:0] o, input int zmode, input int abort_at);
    set_path(o);
    for (int i = 0; i < path.size(); i++) begin
      if (i == abort_at) begin
        step(1'b1, 1'($urandom));
        return;
      end
      step(1'b0, zmode == 2 ? 1'($urandom) : zmode[0]);
    end
  endtask
  function automatic logic [5:0] rand_op();
    logic [5:0] r;
    case ($urandom_range(7))
      0: r = 6'b100011;
      1: r = 6'b101011;
      2: r = 6'b000000;
      3: r = 6'b001000;
      4: r = 6'b000100;
      5: r = 6'b000010;
      default: begin
        r = 6'($urandom);
        while (r inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010})
          r = 6'($urandom);
      end
    endcase
    return r;
  endfunction
  initial begin
    for (int s = 0; s < 16; s++) tab[s] = 15'd0;
    tab[0]  = 15'b1_0_00_0_01_0_1_0_0_0_0_00;
    tab[1]  = 15'b0_0_00_0_11_0_0_0_0_0_0_00;
    tab[2]  = 15'b0_0_00_1_10_0_0_0_0_0_0_00;
    tab[3]  = 15'b0_0_00_0_00_1_0_0_0_0_0_00;
    tab[4]  = 15'b0_0_00_0_00_0_0_0_1_0_1_00;
    tab[5]  = 15'b0_0_00_0_00_1_0_1_0_0_0_00;
    tab[6]  = 15'b0_0_10_1_00_0_0_0_0_0_0_00;
    tab[7]  = 15'b0_0_00_0_00_0_0_0_1_1_0_00;
    tab[8]  = 15'b0_1_01_1_00_0_0_0_0_0_0_01;
    tab[9]  = 15'b0_0_00_1_10_0_0_0_0_0_0_00;
    tab[10] = 15'b1_0_00_0_00_0_0_0_0_0_0_10;
    tab[11] = 15'b0_0_00_0_00_0_0_0_1_0_0_00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_strobes", 32'({ir_write, mem_write, reg_write, pc_en}), 32'd0);
    run_instr(6'b100011, 2, -1);
    run_instr(6'b101011, 2, -1);
    run_instr(6'b000100, 1, -1);
    run_instr(6'b000100, 0, -1);
    run_instr(6'b000000, 2, -1);
    run_instr(6'b001000, 2, -1);
    run_instr(6'b111111, 2, -1);
    run_instr(6'b000010, 2, -1);
    run_instr(6'b101011, 2, 3);
    run_instr(6'b100011, 2, -1);
    for (int n = 0; n < 400; n++)
      run_instr(rand_op(), 2, ($urandom_range(9) == 0) ? int'($urandom_range(4)) : -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
